// File: rtl/pipeline_stage_chain_pkg.sv
// Shared types for the elastic pipeline-register chain.
package pipe_types;

    typedef enum bit {
        pipe_lockstep = 1'b0,
        pipe_elastic  = 1'b1
    } pipe_mode_t;

    function automatic int clog2_plus1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipeline_stage_chain_slot.sv
// One chain slot: a valid bit plus an opaque payload register.
module pipe_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             valid_d,
    input  logic [WIDTH-1:0] data_d,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (clear)
                valid <= 1'b0;
            else if (load)
                valid <= valid_d;
            // payload only moves with a real item; flush leaves it alone
            if (load && valid_d)
                data <= data_d;
        end
    end

endmodule

// File: rtl/pipeline_stage_chain.sv
// DEPTH-slot valid/ready register chain with flush; bubble-collapsing or lockstep stall.
module pipeline_stage_chain
    import pipe_types::*;
#(
    parameter int         WIDTH   = 64,
    parameter int         DEPTH   = 2,
    parameter pipe_mode_t ELASTIC = pipe_elastic
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    input  logic                              flush,
    output logic [DEPTH-1:0]                  slot_valid,
    output logic [clog2_plus1(DEPTH)-1:0]     count
);

    localparam int CW = clog2_plus1(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] q [DEPTH];

    // Ready ripples from the head back to the entry slot.
    always_comb begin
        logic ds;
        load = '0;
        ds   = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ELASTIC == pipe_elastic) begin
                load[i] = !v[i] || ds;
                ds      = load[i];
            end else begin
                load[i] = out_ready || !v[DEPTH-1];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_entry
            pipe_slot #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .load    (load[0]),
                .clear   (flush),
                .valid_d (in_valid),
                .data_d  (in_data),
                .valid   (v[0]),
                .data    (q[0])
            );
        end else begin : g_body
            pipe_slot #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .load    (load[i]),
                .clear   (flush),
                .valid_d (v[i-1]),
                .data_d  (q[i-1]),
                .valid   (v[i]),
                .data    (q[i])
            );
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++)
            count = count + CW'(v[i]);
    end

    assign in_ready   = load[0];
    assign out_valid  = v[DEPTH-1];
    assign out_data   = q[DEPTH-1];
    assign slot_valid = v;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed and random checks of pipeline_stage_chain against a queue scoreboard.
module tb_pipeline_stage_chain;
    import pipe_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: DEPTH=2 elastic, dut1: DEPTH=2 lockstep, dut2: DEPTH=4 elastic
    logic       iv0, ir0, ov0, or0, fl0;
    logic       iv1, ir1, ov1, or1, fl1;
    logic       iv2, ir2, ov2, or2, fl2;
    logic [7:0] id0, od0, id1, od1, id2, od2;
    logic [1:0] sv0, sv1, cnt0, cnt1;
    logic [3:0] sv2;
    logic [2:0] cnt2;

    logic [7:0] q0[$], q1[$], q2[$];
    int         t0[$], t1[$], t2[$];
    int         total = 0;
    int         bad = 0;
    int         cyc_n = 0;
    bit         exact = 1'b0;

    pipeline_stage_chain #(.WIDTH(8), .DEPTH(2), .ELASTIC(pipe_elastic)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(fl0),
        .slot_valid(sv0), .count(cnt0));

    pipeline_stage_chain #(.WIDTH(8), .DEPTH(2), .ELASTIC(pipe_lockstep)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1),
        .slot_valid(sv1), .count(cnt1));

    pipeline_stage_chain #(.WIDTH(8), .DEPTH(4), .ELASTIC(pipe_elastic)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2),
        .slot_valid(sv2), .count(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        total++;
        assert (obs === expd) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    task automatic emit_chk(input string n, input int depth, input logic [7:0] obs,
                            input logic [7:0] expd, input int t_acc);
        chk({n, "_data"}, 32'(obs), 32'(expd));
        if (exact)
            chk({n, "_lat"}, 32'(cyc_n - t_acc), 32'(depth));
        else
            chk({n, "_latmin"}, 32'((cyc_n - t_acc) >= depth), 32'd1);
    endtask

    // Sample at the falling edge, update the scoreboard, then step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        chk("d0_count", 32'(cnt0), 32'(q0.size()));
        chk("d1_count", 32'(cnt1), 32'(q1.size()));
        chk("d2_count", 32'(cnt2), 32'(q2.size()));
        chk("d2_popcnt", 32'(cnt2), 32'($countones(sv2)));
        if (!rst) begin
            if (ov0 && or0) begin
                if (q0.size() == 0) chk("d0_spurious", 32'd1, 32'd0);
                else emit_chk("d0", 2, od0, q0.pop_front(), t0.pop_front());
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) chk("d1_spurious", 32'd1, 32'd0);
                else emit_chk("d1", 2, od1, q1.pop_front(), t1.pop_front());
            end
            if (ov2 && or2) begin
                if (q2.size() == 0) chk("d2_spurious", 32'd1, 32'd0);
                else emit_chk("d2", 4, od2, q2.pop_front(), t2.pop_front());
            end
            if (fl0) begin q0.delete(); t0.delete(); end
            else if (iv0 && ir0) begin q0.push_back(id0); t0.push_back(cyc_n); end
            if (fl1) begin q1.delete(); t1.delete(); end
            else if (iv1 && ir1) begin q1.push_back(id1); t1.push_back(cyc_n); end
            if (fl2) begin q2.delete(); t2.delete(); end
            else if (iv2 && ir2) begin q2.push_back(id2); t2.push_back(cyc_n); end
        end
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        iv0 = v; id0 = d; or0 = r; fl0 = f;
        iv1 = v; id1 = d; or1 = r; fl1 = f;
        #1;
    endtask

    initial begin
        iv2 = 1'b0; id2 = 8'h00; or2 = 1'b1; fl2 = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov0", 32'(ov0), 32'd0);
        chk("rst_od0", 32'(od0), 32'd0);
        chk("rst_sv0", 32'(sv0), 32'd0);
        chk("rst_sv1", 32'(sv1), 32'd0);
        chk("rst_sv2", 32'(sv2), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ir0", 32'(ir0), 32'd1);
        chk("rst_ir1", 32'(ir1), 32'd1);
        chk("rst_ir2", 32'(ir2), 32'd1);

        // reset mid-stream
        drive(1'b1, 8'hA1, 1'b0, 1'b0); cyc();
        drive(1'b1, 8'hA2, 1'b0, 1'b0); cyc();
        chk("mid_od0_pre", 32'(od0), 32'hA1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_ov0", 32'(ov0), 32'd0);
        chk("mid_cnt0", 32'(cnt0), 32'd0);
        chk("mid_od0", 32'(od0), 32'd0);
        chk("mid_ov1", 32'(ov1), 32'd0);
        q0.delete(); t0.delete(); q1.delete(); t1.delete();
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_ir0", 32'(ir0), 32'd1);
        chk("mid_ir1", 32'(ir1), 32'd1);

        // latency and throughput
        exact = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) cyc();
        exact = 1'b0;
        chk("tp_drain0", 32'(q0.size()), 32'd0);
        chk("tp_drain1", 32'(q1.size()), 32'd0);

        // backpressure with simultaneous accept and emit
        drive(1'b1, 8'h11, 1'b0, 1'b0); cyc();
        drive(1'b1, 8'h22, 1'b0, 1'b0); cyc();
        chk("bp_full_ir0", 32'(ir0), 32'd0);
        chk("bp_full_ir1", 32'(ir1), 32'd0);
        chk("bp_cnt0", 32'(cnt0), 32'd2);
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        chk("bp_both_ir0", 32'(ir0), 32'd1);
        chk("bp_head0", 32'(od0), 32'h11);
        cyc();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) cyc();
        chk("bp_drain0", 32'(q0.size()), 32'd0);
        chk("bp_drain1", 32'(q1.size()), 32'd0);

        // bubble collapse vs lockstep hold
        drive(1'b1, 8'h44, 1'b0, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
        drive(1'b1, 8'h55, 1'b0, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bub_sv0", 32'(sv0), 32'h3);
        chk("bub_sv1", 32'(sv1), 32'h2);
        chk("bub_ir0", 32'(ir0), 32'd0);
        chk("bub_ir1", 32'(ir1), 32'd0);
        chk("bub_od1", 32'(od1), 32'h44);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) cyc();
        chk("bub_drain0", 32'(q0.size()), 32'd0);
        chk("bub_drain1", 32'(q1.size()), 32'd0);

        // flush with head transfer and incoming payload
        drive(1'b1, 8'h66, 1'b0, 1'b0); cyc();
        drive(1'b1, 8'h77, 1'b0, 1'b0); cyc();
        drive(1'b1, 8'h88, 1'b1, 1'b1);
        chk("fl_ov0", 32'(ov0), 32'd1);
        chk("fl_od0", 32'(od0), 32'h66);
        chk("fl_ir0", 32'(ir0), 32'd1);
        chk("fl_od1", 32'(od1), 32'h66);
        cyc();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fl_after_ov0", 32'(ov0), 32'd0);
        chk("fl_after_cnt0", 32'(cnt0), 32'd0);
        chk("fl_after_ov1", 32'(ov1), 32'd0);
        repeat (3) cyc();

        // random valid/ready on the 4-deep chain
        for (int k = 0; k < 10000; k++) begin
            iv2 = 1'($urandom_range(0, 1));
            or2 = 1'($urandom_range(0, 1));
            id2 = 8'($urandom);
            #1;
            cyc();
        end
        iv2 = 1'b0; or2 = 1'b1;
        repeat (6) cyc();
        chk("rnd_drain2", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
